ovc_credit_scheduler: RTL and testbench
=======================================

Name: ovc_credit_scheduler

Overview:
Per-output-port output-VC (OVC) manager for a ProNoC router.
- Keeps a credit counter and an allocated/free status bit for each of the V OVCs of one output port.
- Shares free OVCs among P input-side requesters with a two-level round-robin allocator.
- Consumes flit-sent, tail and returned-credit events, and exports per-OVC full, nearly-full and empty flags to switch-mask logic.

Parameters:
V, 4, number of OVCs on the port
B, 4, buffer depth per OVC in the downstream router (max credit)
P, 5, number of requesters (input ports)
CRDTw, 3, credit counter width; must satisfy 2^CRDTw > B

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
init_load  in  1  load credit_init_val into all counters
credit_init_val  in  V*CRDTw  per-OVC initial credit; OVC i occupies bits [i*CRDTw +: CRDTw]
req  in  P  requester i wants an OVC
req_ovc_mask  in  P*V  candidate OVCs of requester i (bits [i*V +: V])
grant  out  P  one-hot winning requester (combinational)
grant_ovc  out  V  one-hot OVC allocated this cycle (combinational)
flit_sent  in  1  a flit left on this port
flit_ovc  in  V  one-hot OVC of the sent flit
flit_tail  in  1  sent flit is a tail (or single-flit packet)
credit_in  in  V  credit returned per OVC (may be multi-hot)
ovc_status  out  V  1 = allocated
ovc_credit  out  V*CRDTw  current credit per OVC
ovc_full  out  V  credit == 0
ovc_nearly_full  out  V  credit == 1
ovc_empty  out  V  credit == B
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset == 0, async):
  - every credit = B; ovc_status = 0; requester pointer = 0; OVC pointer = 0; err = 0.
  - Hence ovc_empty = all 1, ovc_full = 0, ovc_nearly_full = 0 (B > 1).
  - grant and grant_ovc = 0 while in reset.
- OVC free(i) = !ovc_status[i] && credit[i] != 0.
- Requester eligibility: i is eligible iff req[i] && |(req_ovc_mask[i] & free).
- Requester selection: first eligible requester found scanning from the requester pointer upward, wrapping mod P.
- OVC selection: among (mask of winner & free), first OVC found scanning from the OVC pointer upward, wrapping mod V.
- Grants: combinational, same cycle; at most one requester and one OVC per cycle. With no eligible requester, grant = grant_ovc = 0 and pointers hold.
- On a grant, at the next edge:
  - ovc_status[granted OVC] = 1.
  - Requester pointer = winner + 1 mod P.
  - OVC pointer = granted OVC + 1 mod V.
- Requesters keep req asserted until granted; a grant is consumed in its cycle.
- Credit update per OVC, every cycle: next = credit - (flit_sent && flit_ovc[i]) + credit_in[i].
  - Decrement and increment on the same OVC in the same cycle: credit unchanged.
- Release: flit_sent && flit_tail && flit_ovc[i] clears ovc_status[i] at the next edge.
  - The released OVC is grantable from the following cycle, never in the release cycle.
  - Allocation of the same OVC in its release cycle cannot occur because the OVC is not free.
- Error conditions; each sets err, and err stays set until reset:
  - Decrement with credit 0: credit holds at 0.
  - Increment that would exceed B: credit saturates at B.
  - flit_sent on an OVC whose ovc_status is 0.
  - flit_ovc not one-hot while flit_sent = 1: no credit or status change.
- init_load (highest priority after reset):
  - next edge: credits = credit_init_val, all status = 0, pointers = 0.
  - grant and grant_ovc are forced to 0 in the cycle init_load is high; flit and credit events in that cycle are ignored.
  - A credit_init_val of 0 leaves the OVC full (not grantable) until credit_in arrives.
- Reset asserted mid-packet: all state returns to reset values immediately. No partial allocation survives.
- Outputs ovc_status, ovc_credit and the flags come directly from registers or are decoded from registers; no combinational path from inputs.

Test Plan:
- Reset release, V=4, B=4; req=5'b00001, mask0=4'b1111 → grant=00001, grant_ovc=0001; next cycle ovc_status=0001. Next request by requester 0 gets grant_ovc=0010 (pointer rotation).
- Round-robin fairness: req=5'b10011, all masks 1111, requester pointer 0 → requesters win in order 0,1,4,0. OVCs allocated 0001,0010,0100 and no 4th grant to requester 0 while all status=1 except OVC3 → 4th grant gets OVC3 (grant_ovc=1000).
- Credit drain: OVC0 allocated; 4 flit_sent on OVC0, last with flit_tail → credit 4→0, nearly_full at 1, full at 0, status cleared after tail. OVC0 not granted while credit=0; credit_in[0]=1 → OVC0 grantable the next cycle.
- Simultaneous events: credit 2, flit_sent and credit_in on OVC1 in the same cycle → credit stays 2. Five credit_in pulses on an empty OVC → credit saturates at 4, err=1.
- init_load with credit_init_val={0,1,2,3} (OVC3..OVC0) while req is high → grant=0 in that cycle. Next cycle credits 3,2,1,0; OVC3 is never granted until credit_in[3].
- Assert reset mid-allocation (status=0110, credits mixed) → within the same cycle all credits=4, status=0, err=0, grants=0.

Source files
------------

// File: rtl/ovc_credit_scheduler.sv
// rtl/ovc_credit_scheduler.sv - per-output-port OVC credit tracker and two-level round-robin allocator
module ovc_credit_scheduler #(
  parameter int V     = 4,
  parameter int B     = 4,
  parameter int P     = 5,
  parameter int CRDTw = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_load,
  input  logic [V*CRDTw-1:0]   credit_init_val,
  input  logic [P-1:0]         req,
  input  logic [P*V-1:0]       req_ovc_mask,
  output logic [P-1:0]         grant,
  output logic [V-1:0]         grant_ovc,
  input  logic                 flit_sent,
  input  logic [V-1:0]         flit_ovc,
  input  logic                 flit_tail,
  input  logic [V-1:0]         credit_in,
  output logic [V-1:0]         ovc_status,
  output logic [V*CRDTw-1:0]   ovc_credit,
  output logic [V-1:0]         ovc_full,
  output logic [V-1:0]         ovc_nearly_full,
  output logic [V-1:0]         ovc_empty,
  output logic                 err
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam logic [CRDTw-1:0] CMAX = CRDTw'(B);

  logic [CRDTw-1:0] r_credit [V];
  logic [V-1:0]     r_status;
  logic [PW-1:0]    r_req_ptr;
  logic [VW-1:0]    r_ovc_ptr;
  logic             r_err;

  logic [CRDTw-1:0] w_credit_nxt [V];
  logic [V-1:0]     w_status_nxt;
  logic             w_err_evt;
  logic [V-1:0]     w_free;
  logic [P-1:0]     w_elig;
  logic             w_win_found;
  logic [PW-1:0]    w_win_idx;
  logic [V-1:0]     w_win_mask;
  logic             w_ovc_found;
  logic [VW-1:0]    w_ovc_idx;
  logic             w_grant_en;
  logic             w_flit_onehot;
  logic             w_flit_valid;
  logic [V-1:0]     w_dec;
  logic [V-1:0]     w_inc;

  always_comb begin
    ovc_credit      = '0;
    ovc_full        = '0;
    ovc_nearly_full = '0;
    ovc_empty       = '0;
    for (int i = 0; i < V; i++) begin
      ovc_credit[i*CRDTw +: CRDTw] = r_credit[i];
      ovc_full[i]        = (r_credit[i] == '0);
      ovc_nearly_full[i] = (r_credit[i] == CRDTw'(1));
      ovc_empty[i]       = (r_credit[i] == CMAX);
    end
  end

  assign ovc_status = r_status;
  assign err        = r_err;
  assign w_free     = ~r_status & ~ovc_full;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < P; i++) begin
      w_elig[i] = req[i] && (|(req_ovc_mask[i*V +: V] & w_free));
    end
  end

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < P; k++) begin
      if (!w_win_found && w_elig[(int'(r_req_ptr) + k) % P]) begin
        w_win_found = 1'b1;
        w_win_idx   = PW'((int'(r_req_ptr) + k) % P);
      end
    end
  end

  assign w_win_mask = req_ovc_mask[int'(w_win_idx)*V +: V] & w_free;

  always_comb begin
    w_ovc_found = 1'b0;
    w_ovc_idx   = '0;
    for (int k = 0; k < V; k++) begin
      if (!w_ovc_found && w_win_mask[(int'(r_ovc_ptr) + k) % V]) begin
        w_ovc_found = 1'b1;
        w_ovc_idx   = VW'((int'(r_ovc_ptr) + k) % V);
      end
    end
  end

  assign w_grant_en = reset && !init_load && w_win_found && w_ovc_found;
  assign grant      = w_grant_en ? (P'(1) << w_win_idx) : '0;
  assign grant_ovc  = w_grant_en ? (V'(1) << w_ovc_idx) : '0;

  assign w_flit_onehot = (flit_ovc != '0) && ((flit_ovc & (flit_ovc - V'(1))) == '0);
  assign w_flit_valid  = flit_sent && w_flit_onehot && !init_load;
  assign w_dec         = w_flit_valid ? flit_ovc : '0;
  assign w_inc         = init_load ? '0 : credit_in;

  always_comb begin
    w_err_evt    = 1'b0;
    w_status_nxt = r_status;
    for (int i = 0; i < V; i++) begin
      w_credit_nxt[i] = r_credit[i];
    end
    if (flit_sent && !w_flit_onehot && !init_load) begin
      w_err_evt = 1'b1;
    end
    if (w_flit_valid && (|(flit_ovc & ~r_status))) begin
      w_err_evt = 1'b1;
    end
    // A same-cycle send and return on one OVC cancel out.
    for (int i = 0; i < V; i++) begin
      if (w_dec[i] && !w_inc[i]) begin
        if (r_credit[i] == '0) begin
          w_err_evt = 1'b1;
        end else begin
          w_credit_nxt[i] = r_credit[i] - CRDTw'(1);
        end
      end else if (!w_dec[i] && w_inc[i]) begin
        if (r_credit[i] >= CMAX) begin
          w_err_evt = 1'b1;
        end else begin
          w_credit_nxt[i] = r_credit[i] + CRDTw'(1);
        end
      end
    end
    if (w_flit_valid && flit_tail) begin
      w_status_nxt = w_status_nxt & ~flit_ovc;
    end
    if (w_grant_en) begin
      w_status_nxt = w_status_nxt | grant_ovc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < V; i++) begin
        r_credit[i] <= CMAX;
      end
      r_status  <= '0;
      r_req_ptr <= '0;
      r_ovc_ptr <= '0;
      r_err     <= 1'b0;
    end else if (init_load) begin
      for (int i = 0; i < V; i++) begin
        r_credit[i] <= credit_init_val[i*CRDTw +: CRDTw];
      end
      r_status  <= '0;
      r_req_ptr <= '0;
      r_ovc_ptr <= '0;
    end else begin
      for (int i = 0; i < V; i++) begin
        r_credit[i] <= w_credit_nxt[i];
      end
      r_status <= w_status_nxt;
      if (w_grant_en) begin
        r_req_ptr <= (w_win_idx == PW'(P-1)) ? '0 : w_win_idx + PW'(1);
        r_ovc_ptr <= (w_ovc_idx == VW'(V-1)) ? '0 : w_ovc_idx + VW'(1);
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ovc_credit_scheduler.sv
// tb/tb_ovc_credit_scheduler.sv - directed self-checking bench for ovc_credit_scheduler
module tb_ovc_credit_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_load;
  logic [11:0] credit_init_val;
  logic [4:0]  req;
  logic [19:0] req_ovc_mask;
  logic [4:0]  grant;
  logic [3:0]  grant_ovc;
  logic        flit_sent;
  logic [3:0]  flit_ovc;
  logic        flit_tail;
  logic [3:0]  credit_in;
  logic [3:0]  ovc_status;
  logic [11:0] ovc_credit;
  logic [3:0]  ovc_full;
  logic [3:0]  ovc_nearly_full;
  logic [3:0]  ovc_empty;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  ovc_credit_scheduler #(.V(4), .B(4), .P(5), .CRDTw(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .init_load       (init_load),
    .credit_init_val (credit_init_val),
    .req             (req),
    .req_ovc_mask    (req_ovc_mask),
    .grant           (grant),
    .grant_ovc       (grant_ovc),
    .flit_sent       (flit_sent),
    .flit_ovc        (flit_ovc),
    .flit_tail       (flit_tail),
    .credit_in       (credit_in),
    .ovc_status      (ovc_status),
    .ovc_credit      (ovc_credit),
    .ovc_full        (ovc_full),
    .ovc_nearly_full (ovc_nearly_full),
    .ovc_empty       (ovc_empty),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    init_load       = 1'b0;
    credit_init_val = '0;
    req             = '0;
    req_ovc_mask    = '0;
    flit_sent       = 1'b0;
    flit_ovc        = '0;
    flit_tail       = 1'b0;
    credit_in       = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset        = 1'b0;
    req          = 5'b00001;
    req_ovc_mask = 20'hFFFFF;
    tick();
    #1;
    n_cmp++; if (grant !== 5'b0) begin n_bad++; $display("FAIL rst_grant got=%b exp=00000", grant); end
    n_cmp++; if (grant_ovc !== 4'b0) begin n_bad++; $display("FAIL rst_grant_ovc got=%b exp=0000", grant_ovc); end
    n_cmp++; if (ovc_credit !== 12'h924) begin n_bad++; $display("FAIL rst_credit got=%h exp=924", ovc_credit); end
    n_cmp++; if (ovc_status !== 4'b0) begin n_bad++; $display("FAIL rst_status got=%b exp=0000", ovc_status); end
    n_cmp++; if (ovc_empty !== 4'b1111) begin n_bad++; $display("FAIL rst_empty got=%b exp=1111", ovc_empty); end
    n_cmp++; if (ovc_full !== 4'b0 || ovc_nearly_full !== 4'b0) begin n_bad++; $display("FAIL rst_full_nf got=%b/%b exp=0000/0000", ovc_full, ovc_nearly_full); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_basic_grant;
    do_reset();
    req          = 5'b00001;
    req_ovc_mask = 20'h0000F;
    #1;
    n_cmp++; if (grant !== 5'b00001) begin n_bad++; $display("FAIL basic_grant got=%b exp=00001", grant); end
    n_cmp++; if (grant_ovc !== 4'b0001) begin n_bad++; $display("FAIL basic_ovc got=%b exp=0001", grant_ovc); end
    tick();
    n_cmp++; if (ovc_status !== 4'b0001) begin n_bad++; $display("FAIL basic_status got=%b exp=0001", ovc_status); end
    n_cmp++; if (grant_ovc !== 4'b0010) begin n_bad++; $display("FAIL basic_rotate got=%b exp=0010", grant_ovc); end
    tick();
    req = '0;
    n_cmp++; if (ovc_status !== 4'b0011) begin n_bad++; $display("FAIL basic_status2 got=%b exp=0011", ovc_status); end
  endtask

  task automatic test_round_robin;
    logic [4:0] exp_g [5];
    logic [3:0] exp_o [5];
    exp_g[0] = 5'b00001; exp_o[0] = 4'b0001;
    exp_g[1] = 5'b00010; exp_o[1] = 4'b0010;
    exp_g[2] = 5'b10000; exp_o[2] = 4'b0100;
    exp_g[3] = 5'b00001; exp_o[3] = 4'b1000;
    exp_g[4] = 5'b00000; exp_o[4] = 4'b0000;
    do_reset();
    req          = 5'b10011;
    req_ovc_mask = 20'hFFFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (grant !== exp_g[c] || grant_ovc !== exp_o[c]) begin
        n_bad++;
        $display("FAIL rr_step%0d got=%b/%b exp=%b/%b", c, grant, grant_ovc, exp_g[c], exp_o[c]);
      end
      tick();
    end
    req = '0;
    n_cmp++; if (ovc_status !== 4'b1111) begin n_bad++; $display("FAIL rr_status got=%b exp=1111", ovc_status); end
  endtask

  task automatic test_credit_drain;
    logic [2:0] exp_c;
    do_reset();
    req          = 5'b00001;
    req_ovc_mask = 20'h00001;
    #1;
    n_cmp++; if (grant_ovc !== 4'b0001) begin n_bad++; $display("FAIL drain_alloc got=%b exp=0001", grant_ovc); end
    tick();
    req       = '0;
    flit_sent = 1'b1;
    flit_ovc  = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      flit_tail = (k == 3);
      tick();
      exp_c = 3'(3 - k);
      n_cmp++;
      if (ovc_credit[2:0] !== exp_c) begin n_bad++; $display("FAIL drain_credit%0d got=%0d exp=%0d", k, ovc_credit[2:0], exp_c); end
    end
    flit_sent = 1'b0;
    flit_tail = 1'b0;
    flit_ovc  = '0;
    n_cmp++; if (ovc_full[0] !== 1'b1 || ovc_nearly_full[0] !== 1'b0) begin n_bad++; $display("FAIL drain_full got=%b/%b exp=1/0", ovc_full[0], ovc_nearly_full[0]); end
    n_cmp++; if (ovc_status !== 4'b0000) begin n_bad++; $display("FAIL drain_release got=%b exp=0000", ovc_status); end
    req          = 5'b00001;
    req_ovc_mask = 20'h00001;
    credit_in    = 4'b0001;
    #1;
    n_cmp++; if (grant !== 5'b0) begin n_bad++; $display("FAIL drain_nogrant got=%b exp=00000", grant); end
    tick();
    credit_in = '0;
    #1;
    n_cmp++; if (ovc_credit[2:0] !== 3'd1 || ovc_nearly_full[0] !== 1'b1) begin n_bad++; $display("FAIL drain_return got=%0d/%b exp=1/1", ovc_credit[2:0], ovc_nearly_full[0]); end
    n_cmp++; if (grant !== 5'b00001 || grant_ovc !== 4'b0001) begin n_bad++; $display("FAIL drain_regrant got=%b/%b exp=00001/0001", grant, grant_ovc); end
    tick();
    req = '0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL drain_err got=%b exp=0", err); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    req          = 5'b00001;
    req_ovc_mask = 20'h00002;
    #1;
    n_cmp++; if (grant_ovc !== 4'b0010) begin n_bad++; $display("FAIL sim_alloc got=%b exp=0010", grant_ovc); end
    tick();
    req       = '0;
    flit_sent = 1'b1;
    flit_ovc  = 4'b0010;
    tick();
    tick();
    credit_in = 4'b0010;
    tick();
    flit_sent = 1'b0;
    flit_ovc  = '0;
    credit_in = '0;
    n_cmp++; if (ovc_credit[5:3] !== 3'd2) begin n_bad++; $display("FAIL sim_cancel got=%0d exp=2", ovc_credit[5:3]); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sim_err0 got=%b exp=0", err); end
    credit_in = 4'b0100;
    repeat (5) tick();
    credit_in = '0;
    n_cmp++; if (ovc_credit[8:6] !== 3'd4) begin n_bad++; $display("FAIL sim_saturate got=%0d exp=4", ovc_credit[8:6]); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sim_err1 got=%b exp=1", err); end
  endtask

  task automatic test_init_load;
    do_reset();
    credit_init_val = 12'h053;
    init_load       = 1'b1;
    req             = 5'b00001;
    req_ovc_mask    = 20'h0000F;
    #1;
    n_cmp++; if (grant !== 5'b0 || grant_ovc !== 4'b0) begin n_bad++; $display("FAIL init_gate got=%b/%b exp=00000/0000", grant, grant_ovc); end
    tick();
    init_load    = 1'b0;
    req_ovc_mask = 20'h00008;
    #1;
    n_cmp++; if (ovc_credit !== 12'h053) begin n_bad++; $display("FAIL init_credit got=%h exp=053", ovc_credit); end
    n_cmp++; if (ovc_full !== 4'b1000 || ovc_nearly_full !== 4'b0100 || ovc_empty !== 4'b0000) begin n_bad++; $display("FAIL init_flags got=%b/%b/%b exp=1000/0100/0000", ovc_full, ovc_nearly_full, ovc_empty); end
    n_cmp++; if (grant !== 5'b0) begin n_bad++; $display("FAIL init_nogrant got=%b exp=00000", grant); end
    credit_in = 4'b1000;
    tick();
    credit_in = '0;
    #1;
    n_cmp++; if (grant_ovc !== 4'b1000) begin n_bad++; $display("FAIL init_grant3 got=%b exp=1000", grant_ovc); end
    req = '0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    req          = 5'b00001;
    req_ovc_mask = 20'h00006;
    tick();
    tick();
    req = '0;
    n_cmp++; if (ovc_status !== 4'b0110) begin n_bad++; $display("FAIL mid_status got=%b exp=0110", ovc_status); end
    flit_sent = 1'b1;
    flit_ovc  = 4'b0010;
    tick();
    flit_ovc  = 4'b0001;
    tick();
    flit_sent = 1'b0;
    flit_ovc  = '0;
    n_cmp++; if (ovc_credit !== 12'h91B || err !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%h/%b exp=91b/1", ovc_credit, err); end
    req          = 5'b00001;
    req_ovc_mask = 20'h0000F;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (ovc_credit !== 12'h924 || ovc_status !== 4'b0) begin n_bad++; $display("FAIL mid_state got=%h/%b exp=924/0000", ovc_credit, ovc_status); end
    n_cmp++; if (err !== 1'b0 || grant !== 5'b0 || grant_ovc !== 4'b0) begin n_bad++; $display("FAIL mid_out got=%b/%b/%b exp=0/00000/0000", err, grant, grant_ovc); end
    tick();
    clear_inputs();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_credit_drain();
    test_simultaneous();
    test_init_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
